// File: rtl/seq_divider.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seq_divider: restoring divider (DW/VW), one quotient bit per cycle, valid/ready
// both sides. Option macro: SEQ_DIVIDER_FAST_ZERO_EN. Rev 1.0
// ----------------------------------------------------------------------------
module seq_divider #(
  parameter int DW = 17,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [DW-1:0] r_dvd;
  logic [DW-1:0] r_quo;
  logic [VW-1:0] r_dvs;
  logic [VW-1:0] r_low;
  logic [VW:0]   r_prem;
  logic [CW-1:0] r_cnt;

  logic [VW:0]   w_shift;
  logic          w_ge;
  logic [VW:0]   w_next_prem;
  logic [DW-1:0] w_next_quo;

  // Partial remainder stays below the divisor, so VW+1 bits hold the shifted value.
  assign w_shift     = {r_prem[VW-1:0], r_dvd[DW-1]};
  assign w_ge        = (w_shift >= {1'b0, r_dvs});
  assign w_next_prem = w_ge ? (w_shift - {1'b0, r_dvs}) : w_shift;
  assign w_next_quo  = {r_quo[DW-2:0], w_ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      r_dvd       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_low       <= '0;
      r_prem      <= '0;
      r_cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= BUSY;
            in_ready <= 1'b0;
            r_dvd    <= dividend;
            r_dvs    <= divisor;
            r_low    <= dividend[VW-1:0];
            r_quo    <= '0;
            r_prem   <= '0;
            r_cnt    <= CW'(DW - 1);
`ifdef SEQ_DIVIDER_FAST_ZERO_EN
            // Trivial operands resolve immediately with the same result the loop would give.
            if ((divisor == '0) || (dividend == '0)) begin
              state       <= DONE;
              out_valid   <= 1'b1;
              quotient    <= (divisor == '0) ? '1 : '0;
              remainder   <= (divisor == '0) ? dividend[VW-1:0] : '0;
              div_by_zero <= (divisor == '0);
            end
`endif
          end
        end
        BUSY: begin
          r_prem <= w_next_prem;
          r_quo  <= w_next_quo;
          r_dvd  <= {r_dvd[DW-2:0], 1'b0};
          r_cnt  <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            quotient    <= w_next_quo;
            remainder   <= (r_dvs == '0) ? r_low : w_next_prem[VW-1:0];
            div_by_zero <= (r_dvs == '0);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_seq_divider: directed vectors, queue scoreboard with independent monitor.
// ----------------------------------------------------------------------------
module tb_seq_divider;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  seq_divider #(.DW(17), .VW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

`ifdef SEQ_DIVIDER_FAST_ZERO_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 17;
`endif

  typedef struct {
    logic [16:0] q;
    logic [7:0]  r;
    logic        dbz;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic prev_v = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: one scoreboard entry per rising out_valid.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid && !prev_v) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: quotient=%0h remainder=%0h with empty scoreboard", quotient, remainder);
        end else begin
          mon_e = sb.pop_front();
          chk("quotient",    32'(quotient),    32'(mon_e.q));
          chk("remainder",   32'(remainder),   32'(mon_e.r));
          chk("div_by_zero", 32'(div_by_zero), 32'(mon_e.dbz));
          chk("latency",     32'(cyc - mon_e.acc), 32'(mon_e.lat));
        end
      end
      prev_v = out_valid;
    end
  end

  task automatic issue(input logic [16:0] a, input logic [7:0] b,
                       input logic [16:0] eq, input logic [7:0] er, input logic ed,
                       input bit push);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: in_ready=%0b required 1", in_ready);
      return;
    end
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 17'($urandom);
    divisor  = 8'($urandom);
    if (push) begin
      e.q   = eq;
      e.r   = er;
      e.dbz = ed;
      e.acc = cyc;
      e.lat = ((b == 8'd0) || (a == 17'd0)) ? ZLAT : 17;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: pending=%0d required 0", sb.size());
      sb.delete();
    end
  endtask

  logic [7:0] pa [20] = '{8'h63, 8'h7B, 8'hFA, 8'hFF, 8'h01, 8'h00, 8'h80, 8'h12, 8'hAB, 8'h7F,
                          8'h55, 8'h0F, 8'hC3, 8'h99, 8'h01, 8'hFF, 8'h40, 8'hE7, 8'h2A, 8'hB4};
  logic [7:0] pb [20] = '{8'hC7, 8'h2D, 8'h04, 8'hFF, 8'h01, 8'h05, 8'h02, 8'h34, 8'hCD, 8'h81,
                          8'hAA, 8'hF0, 8'h3C, 8'h11, 8'hFF, 8'h01, 8'h40, 8'h19, 8'h06, 8'h9D};

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("reset_in_ready",  32'(in_ready),    32'd1);
    chk("reset_out_valid", 32'(out_valid),   32'd0);
    chk("reset_quotient",  32'(quotient),    32'd0);
    chk("reset_remainder", 32'(remainder),   32'd0);
    chk("reset_dbz",       32'(div_by_zero), 32'd0);

    issue(17'd40000,  8'd200, 17'd200,    8'd0,    1'b0, 1'b1);
    issue(17'd1000,   8'd7,   17'd142,    8'd6,    1'b0, 1'b1);
    issue(17'h1FFFF,  8'd1,   17'd131071, 8'd0,    1'b0, 1'b1);
    issue(17'd65025,  8'd255, 17'd255,    8'd0,    1'b0, 1'b1);
    issue(17'd12345,  8'd0,   17'h1FFFF,  8'h39,   1'b1, 1'b1);
    drain();

    // Backpressure: result held, new requests ignored.
    out_ready = 1'b0;
    issue(17'd5000, 8'd3, 17'd1666, 8'd2, 1'b0, 1'b1);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      dividend = 17'd9;
      divisor  = 8'd2;
      #1;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready",  32'(in_ready),  32'd0);
      chk("bp_quotient",  32'(quotient),  32'd1666);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready",  32'(in_ready),  32'd1);
    repeat (25) @(negedge clk);

    // Reset during BUSY discards the pending result.
    issue(17'd1000, 8'd7, 17'd0, 8'd0, 1'b0, 1'b0);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready",  32'(in_ready),    32'd1);
    chk("midrst_out_valid", 32'(out_valid),   32'd0);
    chk("midrst_quotient",  32'(quotient),    32'd0);
    chk("midrst_remainder", 32'(remainder),   32'd0);
    chk("midrst_dbz",       32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(17'd19701, 8'd199, 17'd99, 8'd0, 1'b0, 1'b1);
    drain();

    // Multiplier round trip: (a*b)/b == a, remainder 0.
    for (int i = 0; i < 20; i++) begin
      issue(17'(pa[i]) * 17'(pb[i]), pb[i], 17'(pa[i]), 8'd0, 1'b0, 1'b1);
    end
    drain();
    repeat (25) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
